// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame step/clear/draw/swap sequencer with overrun detection
//
// Each frame tick starts one physics step, then a back-buffer clear, then one
// draw per object. At the following tick the front/back buffers swap. Ticks that
// arrive while that work is still in progress are counted as overruns.
//
// Optional feature macro: SCHED_PERF_EN (adds busy_cycles)
//
// Ports:
//   clock_162    in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   run scheduler; sampled in IDLE and at swap
//   vsync        in   VSYNC, same clock domain; active level VSYNC_ACTIVE
//   step_start   out  one-cycle pulse: physics timestep begins
//   step_done    in   one-cycle pulse: timestep complete
//   clr_we       out  back-buffer clear write strobe
//   clr_addr     out  clear write address
//   draw_start   out  one-cycle pulse: draw object draw_idx
//   draw_idx     out  object index being drawn
//   draw_done    in   one-cycle pulse: object draw complete
//   front_sel    out  framebuffer shown by VGA (back buffer = ~front_sel)
//   frame_cnt    out  completed swaps, wrapping
//   overrun      out  sticky: tick arrived while work unfinished
//   overrun_cnt  out  overrun events, saturating at 255
//   busy_cycles  out  (SCHED_PERF_EN) cycles from step_start to last draw_done
module frame_scheduler #(
  parameter int   N_OBJ        = 8,
  parameter int   FB_WORDS     = 120000,
  parameter int   FB_ADDR_W    = 17,
  parameter logic VSYNC_ACTIVE = 1'b1,
  localparam int  IDX_W        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                 clock_162,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 vsync,
  output logic                 step_start,
  input  logic                 step_done,
  output logic                 clr_we,
  output logic [FB_ADDR_W-1:0] clr_addr,
  output logic                 draw_start,
  output logic [IDX_W-1:0]     draw_idx,
  input  logic                 draw_done,
`ifdef SCHED_PERF_EN
  output logic [23:0]          busy_cycles,
`endif
  output logic                 front_sel,
  output logic [15:0]          frame_cnt,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, STEP, CLEAR, DRAW_ISSUE, DRAW_WAIT, SWAP_WAIT
  } state_t;

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_OBJ - 1);

  state_t state;
  logic   vsync_q;
  logic   frame_tick;
  logic   in_work;

  // Rising edge into the active level; holding vsync active yields one tick only.
  assign frame_tick = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
  assign in_work    = state inside {STEP, CLEAR, DRAW_ISSUE, DRAW_WAIT};

  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= ~VSYNC_ACTIVE;
      step_start  <= 1'b0;
      clr_we      <= 1'b0;
      clr_addr    <= '0;
      draw_start  <= 1'b0;
      draw_idx    <= '0;
      front_sel   <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      vsync_q    <= vsync;
      step_start <= 1'b0;
      draw_start <= 1'b0;

      // Work keeps going through an overrun; the swap simply slips a frame.
      if (frame_tick && in_work) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (frame_tick && enable) begin
            state      <= STEP;
            step_start <= 1'b1;
          end
        end
        STEP: begin
          // step_start is high only in the first STEP cycle, so a done in
          // the same cycle as the start is ignored.
          if (step_done && !step_start) begin
            state    <= CLEAR;
            clr_we   <= 1'b1;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            clr_we     <= 1'b0;
            clr_addr   <= '0;
            draw_idx   <= '0;
            draw_start <= 1'b1;
            state      <= DRAW_ISSUE;
          end else begin
            clr_addr <= clr_addr + FB_ADDR_W'(1);
          end
        end
        DRAW_ISSUE: begin
          state <= DRAW_WAIT;
        end
        DRAW_WAIT: begin
          if (draw_done) begin
            if (draw_idx == LAST_IDX) begin
              state <= SWAP_WAIT;
            end else begin
              draw_idx   <= draw_idx + IDX_W'(1);
              draw_start <= 1'b1;
              state      <= DRAW_ISSUE;
            end
          end
        end
        SWAP_WAIT: begin
          if (frame_tick) begin
            front_sel <= ~front_sel;
            frame_cnt <= frame_cnt + 16'd1;
            if (enable) begin
              state      <= STEP;
              step_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  logic [23:0] work_cnt;

  // work_cnt counts work cycles including the step_start cycle; the final
  // draw_done cycle is added when the result is captured.
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      work_cnt    <= '0;
      busy_cycles <= '0;
    end else if (in_work) begin
      if (step_start) begin
        work_cnt <= 24'd1;
      end else if (work_cnt != 24'hFFFFFF) begin
        work_cnt <= work_cnt + 24'd1;
      end
      if (state == DRAW_WAIT && draw_done && draw_idx == LAST_IDX) begin
        busy_cycles <= (work_cnt == 24'hFFFFFF) ? work_cnt : work_cnt + 24'd1;
      end
    end
  end
`endif

endmodule
